// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and width helpers for the digit-serial adder/subtractor.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-digit operation still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_rca.sv
// Combinational DIGIT-bit ripple-carry slice; exposes the carry into its top bit.
module rca_nbit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             cin,
  output logic [DIGIT-1:0] S,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial A +/- B with valid/ready handshakes; one DIGIT-bit slice per clock, LSD first.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(N);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              step;
  logic              last;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_shift;
  logic [WIDTH-1:0]  b_shift;
  logic [WIDTH-1:0]  s_shift;
  logic              carry;
  logic              cout_reg;
  logic              ovf_reg;
  logic [DIGIT-1:0]  slice_sum;
  logic              slice_cout;
  logic              slice_cmsb;

  rca_nbit #(.DIGIT(DIGIT)) u_rca (
    .A     (a_shift[DIGIT-1:0]),
    .B     (b_shift[DIGIT-1:0]),
    .cin   (carry),
    .S     (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = (cnt == CW'(N - 1));
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, carry and digit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_shift  <= '0;
      b_shift  <= '0;
      s_shift  <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1; the +1 rides in the initial carry.
      a_shift <= A;
      b_shift <= sub ? ~B : B;
      carry   <= cin ^ sub;
      cnt     <= '0;
    end else if (step) begin
      a_shift <= a_shift >> DIGIT;
      b_shift <= b_shift >> DIGIT;
      s_shift <= WIDTH'({slice_sum, s_shift} >> DIGIT);
      carry   <= slice_cout;
      if (last) begin
        cout_reg <= slice_cout;
        ovf_reg  <= slice_cmsb ^ slice_cout;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign S         = s_shift;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed vector table, handshake corner cases and a randomized DIGIT sweep for digit_serial_addsub.
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic        sub;
  logic [31:0] S;
  logic        cout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic        sw_rst = 1'b1;

  int checks     = 0;
  int failures   = 0;
  int sweep_done = 0;

  digit_serial_addsub #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation on the DIGIT=4 instance; called at a negedge with the DUT idle.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = v.a; B = v.b; cin = v.cin; sub = v.sub;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~v.a; B = ~v.b; cin = ~v.cin; sub = ~v.sub;
    check({tag, ".in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 8);
    check({tag, ".S"}, S, v.s);
    check({tag, ".cout"}, cout, v.cout);
    check({tag, ".ovf"}, ovf, v.ovf);
    @(negedge clk);
    check({tag, ".back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.S", S, 0);
    check("reset.cout_ovf", {cout, ovf}, 2'b00);
    rst = 1'b0;
    sw_rst = 1'b0;
    @(negedge clk);

    //          a             b             cin   sub   s             cout  ovf
    vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold and a waiting request must not slip in.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A = 32'h10; B = 32'h20; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    A = 32'h3; B = 32'h4;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp.latency", lat, 8);
    check("bp.S", S, 32'h30);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp.hold%0d", k), {S, cout, ovf, in_ready, out_valid}, {32'h30, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_idle", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    check("bp.second_accepted", in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp.second_latency", lat, 8);
    check("bp.second_S", S, 32'h7);
    @(negedge clk);

    // Reset while digit 3 is next to be processed.
    in_valid = 1'b1;
    A = 32'h0F0F_0F0F; B = 32'h0101_0101; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.partial_S_nonzero", (S != 0), 1);
    rst = 1'b1;
    #1;
    check("midrst.in_ready", in_ready, 1);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.S", S, 0);
    check("midrst.cout_ovf", {cout, ovf}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(vecs[7], "post_rst");

    for (int t = 0; t < 60000 && sweep_done < 3; t++) @(negedge clk);
    check("sweep_done", sweep_done, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Randomized sweep over DIGIT = 1, 4, 32 against an arithmetic reference model.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned D  = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
    localparam int unsigned NL = 32 / D;

    logic        iv;
    logic        ir;
    logic        ci;
    logic        sb;
    logic        co;
    logic        ov;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;

    digit_serial_addsub #(.WIDTH(32), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (sw_rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .A         (a),
      .B         (b),
      .cin       (ci),
      .sub       (sb),
      .S         (s),
      .cout      (co),
      .ovf       (ov),
      .out_valid (vld),
      .out_ready (1'b1)
    );

    initial begin
      int          lat;
      logic [32:0] ext;
      logic [31:0] es;
      logic        eco;
      logic        eov;
      iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom);
        sb = 1'($urandom);
        ext = {1'b0, a} + {1'b0, (sb ? ~b : b)} + 33'(ci ^ sb);
        es  = ext[31:0];
        eco = ext[32];
        eov = sb ? ((a[31] != b[31]) && (es[31] != a[31]))
                 : ((a[31] == b[31]) && (es[31] != a[31]));
        iv = 1'b1;
        check($sformatf("sweep_d%0d.in_ready", D), ir, 1);
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!vld && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sweep_d%0d.latency", D), lat, NL);
        check($sformatf("sweep_d%0d.S a=%h b=%h", D, a, b), s, es);
        check($sformatf("sweep_d%0d.cout", D), co, eco);
        check($sformatf("sweep_d%0d.ovf", D), ov, eov);
        @(negedge clk);
      end
      sweep_done++;
    end
  end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, digit-serial adder/subtractor that computes WIDTH-bit sums and differences one DIGIT-bit slice per clock, least-significant digit first. Each slice uses a combinational ripple-carry adder, and the carry is registered between slices. The block trades latency for area. It sits in the datapath wherever an operand pair arrives through a valid/ready handshake and a wide single-cycle adder is not justified.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- cin  in  1  carry-in (add) or borrow-in (sub)
- sub  in  1  0: S = A + B + cin; 1: S = A − B − cin
- S  out  WIDTH  result, held stable while out_valid is high
- cout  out  1  carry-out; in subtract mode, 1 means no borrow
- ovf  out  1  two's-complement signed overflow
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result

## Operation
- N = WIDTH/DIGIT digits.
- The state machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, capture A into the A shift register and (sub ? ~B : B) into the B shift register.
  - Set carry register = cin ^ sub, clear the digit counter, go to BUSY.
- BUSY:
  - Add the low DIGIT bits of both shift registers plus the carry register.
  - Shift the sum digit into the top of the S shift register, shift both operand registers right by DIGIT, and register the slice carry.
  - Increment the counter. On the edge that processes digit N−1, go to DONE.
- DONE:
  - out_valid = 1. S, cout and ovf are frozen.
  - When out_ready is high, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid in those states is ignored; the producer must hold its data.
- cout = carry out of digit N−1.
- ovf = (carry into bit WIDTH−1) XOR cout, captured from the last slice.
- cin and sub are sampled only at acceptance. Changes after acceptance have no effect.
- Reset, at any time including mid-operation:
  - state = IDLE, in_ready = 1.
  - out_valid = 0, S = 0, cout = 0, ovf = 0.
  - Counter, carry and shift registers are cleared. Any in-flight operation is discarded.
- Sums wrap modulo 2^WIDTH. No saturation.

## Timing
- Acceptance edge T0 (IDLE with in_valid high).
- Digit k is processed on edge T(k+1).
- out_valid rises after edge TN, so latency is N cycles from acceptance to result.
  - Example: 8 cycles for WIDTH=32, DIGIT=4.
  - Example: 1 cycle for DIGIT=WIDTH.
- A result consumed at edge Tc returns the block to IDLE. The next operands are accepted no earlier than Tc+1.
- Throughput is one operation per N+2 cycles with back-to-back handshakes.
- out_ready = 0 holds DONE indefinitely. Outputs do not change.
- Digit counter width is max(1, clog2(N)). The counter does not wrap within an operation.

## Structure
- Shared package/header holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - width-derivation constants (N, counter width)
- One sub-module, rca_nbit:
  - parameter DIGIT
  - ports A, B, cin, S, cout, plus c_msb (carry into the top bit, used for ovf)
  - purely combinational ripple of full adders
- The top level contains the FSM, counter, shift registers and carry register.

## Test plan
- Add, WIDTH=32, DIGIT=4. A=0x0000_FFFF, B=0x0000_0001, cin=0 → after 8 cycles S=0x0001_0000, cout=0, ovf=0.
- Signed overflow, add. A=0x7FFF_FFFF, B=1, cin=0 → S=0x8000_0000, ovf=1, cout=0.
- Subtract with borrow-in. sub=1, A=5, B=7, cin=1 → S=0xFFFF_FFFD, cout=0. A separate operation with sub=1, A=7, B=5, cin=0 → S=2, cout=1.
- Backpressure. out_ready held 0 for 5 cycles after out_valid:
  - S, cout, ovf stay stable; in_ready stays 0.
  - A second in_valid during this time is not accepted.
  - Releasing out_ready accepts the second operation one cycle later.
- Reset mid-operation. Assert rst during BUSY digit 3 → immediately in_ready=1, out_valid=0, S=0. A new operation afterwards produces a correct result.
- Parameter sweep. DIGIT ∈ {1, 4, 32}, WIDTH=32, 1000 random operations each (A, B, cin, sub) checked against a reference model. Latency equals 32, 8 and 1 cycles respectively.
